// File: rtl/fp_seq_pkg.sv
// Shared definitions for the dot-product sequencer: FSM encoding, default sizes
// and the floating-point zero pattern.
package fp_seq_pkg;

    localparam int unsigned DEPTH_DEFAULT   = 8;
    localparam int unsigned TIMEOUT_DEFAULT = 64;
    localparam logic [31:0] FP_ZERO         = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/fp_operand_buf.sv
// Operand storage: DEPTH entries of {a, b}, one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module fp_operand_buf
    import fp_seq_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        we_i,
    input  logic [2:0]  wr_addr_i,
    input  logic [63:0] wr_data_i,
    input  logic [2:0]  rd_addr_i,
    output logic [63:0] rd_data_o
);

    logic [63:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i && (32'(wr_addr_i) < DEPTH)) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/fp_dot_sequencer.sv
// Sequences a dot product over the operand buffer through an external a*b+c MAC,
// one element in flight at a time, with a per-result timeout.
//
// state | meaning
// IDLE  | accept start and operand writes
// ISSUE | present a/b/acc to the MAC for one cycle
// WAIT  | wait for the MAC result or the timeout
// DONE  | pulse done, publish the accumulator
module fp_dot_sequencer
    import fp_seq_pkg::*;
#(
    parameter int unsigned DEPTH   = DEPTH_DEFAULT,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  logic [31:0] wr_a,
    input  logic [31:0] wr_b,
    input  logic        start,
    input  logic [3:0]  len,
    output logic [31:0] mac_a_tdata,
    output logic [31:0] mac_b_tdata,
    output logic [31:0] mac_c_tdata,
    output logic        mac_tvalid,
    input  logic        mac_res_tvalid,
    input  logic [31:0] mac_res_tdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] result
);

    localparam int unsigned CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
    localparam logic [4:0] DEPTH_L   = 5'(DEPTH);

    state_e        state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic [3:0]    len_q, len_d;
    logic [31:0]   acc_q, acc_d;
    logic [CW-1:0] tmo_q, tmo_d;
    logic          error_q, error_d;
    logic [31:0]   result_q, result_d;
    logic [63:0]   shadow_q, shadow_d;
    logic [2:0]    shadow_addr_q, shadow_addr_d;
    logic          shadow_vld_q, shadow_vld_d;

    logic [2:0]    rd_addr;
    logic [63:0]   rd_data;
    logic [63:0]   operand;

    // In IDLE the read port looks at the write address so a write colliding with
    // start can be shadowed: the run then still sees the pre-write entry.
    assign rd_addr = (state_q == IDLE) ? wr_addr : idx_q[2:0];

    fp_operand_buf #(.DEPTH(DEPTH)) u_buf (
        .clk       (clk),
        .we_i      (wr_en && (state_q == IDLE)),
        .wr_addr_i (wr_addr),
        .wr_data_i ({wr_a, wr_b}),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    assign operand = (shadow_vld_q && (shadow_addr_q == idx_q[2:0])) ? shadow_q : rd_data;

    assign mac_a_tdata = operand[63:32];
    assign mac_b_tdata = operand[31:0];
    assign mac_c_tdata = acc_q;
    assign mac_tvalid  = (state_q == ISSUE);
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign error       = error_q;
    assign result      = result_q;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        len_d         = len_q;
        acc_d         = acc_q;
        tmo_d         = tmo_q;
        error_d       = error_q;
        result_d      = result_q;
        shadow_d      = shadow_q;
        shadow_addr_d = shadow_addr_q;
        shadow_vld_d  = shadow_vld_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d         = '0;
                    acc_d         = FP_ZERO;
                    tmo_d         = '0;
                    error_d       = 1'b0;
                    result_d      = FP_ZERO;
                    len_d         = len;
                    shadow_vld_d  = wr_en;
                    shadow_addr_d = wr_addr;
                    shadow_d      = rd_data;
                    if (len == 4'd0) begin
                        state_d = DONE;
                    end else if ({1'b0, len} > DEPTH_L) begin
                        error_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                tmo_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (mac_res_tvalid) begin
                    acc_d   = mac_res_tdata;
                    idx_d   = idx_q + 4'd1;
                    tmo_d   = '0;
                    state_d = ((idx_q + 4'd1) < len_q) ? ISSUE : DONE;
                end else if (tmo_q == TMO_LAST) begin
                    error_d = 1'b1;
                    state_d = DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            DONE: begin
                result_d = acc_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            len_q         <= '0;
            acc_q         <= FP_ZERO;
            tmo_q         <= '0;
            error_q       <= 1'b0;
            result_q      <= FP_ZERO;
            shadow_q      <= '0;
            shadow_addr_q <= '0;
            shadow_vld_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            len_q         <= len_d;
            acc_q         <= acc_d;
            tmo_q         <= tmo_d;
            error_q       <= error_d;
            result_q      <= result_d;
            shadow_q      <= shadow_d;
            shadow_addr_q <= shadow_addr_d;
            shadow_vld_q  <= shadow_vld_d;
        end
    end

endmodule

// File: tb/tb_fp_dot_sequencer.sv
// Self-checking bench for fp_dot_sequencer: behavioural single-precision MAC with
// programmable latency, directed corner cases and randomized dot products.
module tb_fp_dot_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [31:0] wr_a = '0;
    logic [31:0] wr_b = '0;
    logic        start = 1'b0;
    logic [3:0]  len = '0;
    logic [31:0] mac_a_tdata, mac_b_tdata, mac_c_tdata;
    logic        mac_tvalid;
    logic        mac_res_tvalid = 1'b0;
    logic [31:0] mac_res_tdata = '0;
    logic        busy, done, error;
    logic [31:0] result;

    always #5 clk = ~clk;

    fp_dot_sequencer #(.DEPTH(8), .TIMEOUT(64)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_a           (wr_a),
        .wr_b           (wr_b),
        .start          (start),
        .len            (len),
        .mac_a_tdata    (mac_a_tdata),
        .mac_b_tdata    (mac_b_tdata),
        .mac_c_tdata    (mac_c_tdata),
        .mac_tvalid     (mac_tvalid),
        .mac_res_tvalid (mac_res_tvalid),
        .mac_res_tdata  (mac_res_tdata),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .result         (result)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Single <-> double conversion for normal numbers; truncating on the way back.
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) return 0.0;
        d = {f[31], 11'({3'b000, f[30:23]}) + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        if (r == 0.0) return 32'h0;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fmac(input logic [31:0] a, b, c);
        return r2f(f2r(a) * f2r(b) + f2r(c));
    endfunction

    // Behavioural MAC and issue monitor
    int          mac_lat  = 3;
    bit          mac_mute = 1'b0;
    bit          glitch   = 1'b0;
    bit          mac_pend = 1'b0;
    int          mac_cnt  = 0;
    logic [31:0] mac_val  = '0;
    int          issue_cnt = 0;
    logic [31:0] run_acc  = '0;
    logic [31:0] exp_a [8];
    logic [31:0] exp_b [8];
    logic [31:0] mb_a  [8];
    logic [31:0] mb_b  [8];

    always @(negedge clk) begin
        if (!rst_n) begin
            mac_pend       = 1'b0;
            mac_res_tvalid = 1'b0;
        end else begin
            mac_res_tvalid = 1'b0;
            if (mac_pend) begin
                mac_cnt--;
                if (mac_cnt == 0) begin
                    mac_res_tvalid = 1'b1;
                    mac_res_tdata  = mac_val;
                    mac_pend       = 1'b0;
                end
            end
            if (mac_tvalid) begin
                if (issue_cnt < 8) begin
                    chk("mac_a", mac_a_tdata, exp_a[issue_cnt]);
                    chk("mac_b", mac_b_tdata, exp_b[issue_cnt]);
                end
                chk("mac_c", mac_c_tdata, run_acc);
                mac_val = fmac(mac_a_tdata, mac_b_tdata, mac_c_tdata);
                run_acc = mac_val;
                issue_cnt++;
                if (!mac_mute) begin
                    mac_pend = 1'b1;
                    mac_cnt  = mac_lat;
                end
            end
            if (glitch) begin
                mac_res_tvalid = 1'b1;
                mac_res_tdata  = 32'hDEAD_BEEF;
            end
        end
    end

    task automatic wr(input logic [2:0] addr, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = addr; wr_a = a; wr_b = b;
        @(negedge clk);
        wr_en = 1'b0;
        mb_a[addr] = a;
        mb_b[addr] = b;
    endtask

    function automatic logic [31:0] rnd_fp();
        return {1'($urandom), 8'($urandom_range(120, 134)), 23'($urandom)};
    endfunction

    task automatic arm_op();
        exp_a     = mb_a;
        exp_b     = mb_b;
        issue_cnt = 0;
        run_acc   = '0;
    endtask

    task automatic run_op(input int l, input int lat, input bit mute, input bit disturb,
                          input bit sc_wr, input logic [2:0] sc_addr,
                          input logic [31:0] sc_a, input logic [31:0] sc_b);
        int          cyc;
        int          exp_cyc;
        int          exp_iss;
        logic [31:0] exp_res;
        logic        exp_err;
        @(negedge clk);
        mac_lat  = lat;
        mac_mute = mute;
        arm_op();
        exp_res = '0;
        exp_err = 1'b0;
        if (l == 0) begin
            exp_cyc = 1; exp_iss = 0;
        end else if (l > 8) begin
            exp_cyc = 1; exp_iss = 0; exp_err = 1'b1;
        end else if (mute) begin
            exp_cyc = 66; exp_iss = 1; exp_err = 1'b1;
        end else begin
            for (int i = 0; i < l; i++) exp_res = fmac(exp_a[i], exp_b[i], exp_res);
            exp_cyc = l * (lat + 1) + 1;
            exp_iss = l;
        end
        start = 1'b1;
        len   = 4'(l);
        if (sc_wr) begin
            wr_en = 1'b1; wr_addr = sc_addr; wr_a = sc_a; wr_b = sc_b;
            mb_a[sc_addr] = sc_a;
            mb_b[sc_addr] = sc_b;
        end
        @(negedge clk);
        start = 1'b0;
        wr_en = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        cyc = 0;
        while (done !== 1'b1 && cyc < 300) begin
            if (disturb && cyc == 2) begin
                start = 1'b1; len = 4'd1;
                wr_en = 1'b1; wr_addr = 3'd0; wr_a = 32'h7F7F_FFFF; wr_b = 32'h7F7F_FFFF;
            end else begin
                start = 1'b0; wr_en = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        wr_en = 1'b0;
        chk("done_cycle", 32'(cyc + 1), 32'(exp_cyc));
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("busy_end", 32'(busy), 32'd0);
        chk("result", result, exp_res);
        chk("error", 32'(error), 32'(exp_err));
        chk("issue_count", 32'(issue_cnt), 32'(exp_iss));
    endtask

    initial begin
        bit saw_done;
        for (int i = 0; i < 8; i++) begin
            mb_a[i] = '0; mb_b[i] = '0; exp_a[i] = '0; exp_b[i] = '0;
        end
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_result", result, 32'h0);
        chk("rst_mac_tvalid", 32'(mac_tvalid), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) wr(3'(i), 32'h0, 32'h0);
        wr(3'd0, 32'h3F80_0000, 32'h4080_0000);
        wr(3'd1, 32'h4000_0000, 32'h40A0_0000);
        wr(3'd2, 32'h4040_0000, 32'h40C0_0000);

        run_op(3, 3, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        chk("dot_32", result, 32'h4200_0000);
        run_op(0, 3, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        run_op(9, 3, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        run_op(1, 3, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        run_op(3, 3, 1'b0, 1'b1, 1'b0, 3'd0, 32'h0, 32'h0);
        chk("disturb_result", result, 32'h4200_0000);

        // Write colliding with start: this run uses the old entry 1, the next the new one
        run_op(3, 2, 1'b0, 1'b0, 1'b1, 3'd1, 32'h4100_0000, 32'h3F80_0000);
        run_op(3, 2, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);

        // A stray MAC result while idle must change nothing
        @(posedge clk); glitch = 1'b1;
        @(posedge clk); glitch = 1'b0;
        repeat (2) @(negedge clk);
        chk("glitch_busy", 32'(busy), 32'd0);
        chk("glitch_result", result, fmac(32'h4040_0000, 32'h40C0_0000,
                                          fmac(32'h4100_0000, 32'h3F80_0000,
                                               fmac(32'h3F80_0000, 32'h4080_0000, 32'h0))));

        // Reset while waiting on the MAC
        wr(3'd1, 32'h4000_0000, 32'h40A0_0000);
        @(negedge clk);
        mac_lat = 3; mac_mute = 1'b0;
        arm_op();
        start = 1'b1; len = 4'd3;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_mac_tvalid", 32'(mac_tvalid), 32'd0);
        saw_done = done;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            saw_done = saw_done | done;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            saw_done = saw_done | done;
        end
        chk("midrst_no_done", 32'(saw_done), 32'd0);
        chk("midrst_result", result, 32'h0);
        for (int i = 0; i < 3; i++) wr(3'(i), mb_a[i], mb_b[i]);
        run_op(3, 3, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        chk("post_rst_dot", result, 32'h4200_0000);

        for (int t = 0; t < 8; t++) begin
            int l;
            for (int i = 0; i < 8; i++) wr(3'(i), rnd_fp(), rnd_fp());
            l = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, 8));
            run_op(l, int'($urandom_range(1, 4)), 1'b0, 1'($urandom_range(0, 1)), 1'b0,
                   3'd0, 32'h0, 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fp_dot_sequencer.md
FP_DOT_SEQUENCER -- requirements
Module: fp_dot_sequencer

Interface
REQ-001 Parameter DEPTH, default 8, operand buffer entries (a/b pairs).
REQ-002 Parameter TIMEOUT, default 64, max cycles to wait for one MAC result before aborting.
REQ-003 Port clk, input, 1, single clock; all logic rising-edge.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port wr_en, input, 1, operand buffer write strobe.
REQ-006 Port wr_addr, input, 3, operand buffer write index.
REQ-007 Port wr_a, input, 32, IEEE-754 single operand a.
REQ-008 Port wr_b, input, 32, IEEE-754 single operand b.
REQ-009 Port start, input, 1, begin dot product when idle.
REQ-010 Port len, input, 4, element count (0..15 encodable).
REQ-011 Port mac_a_tdata / mac_b_tdata / mac_c_tdata, output, 32 each, operands to the downstream floating-point MAC (a*b+c).
REQ-012 Port mac_tvalid, output, 1, drives all three MAC operand tvalid inputs.
REQ-013 Port mac_res_tvalid, input, 1, MAC result valid.
REQ-014 Port mac_res_tdata, input, 32, MAC result.
REQ-015 Port busy, output, 1, high outside IDLE.
REQ-016 Port done, output, 1, one-cycle completion pulse.
REQ-017 Port error, output, 1, sticky until next accepted start: len>DEPTH or timeout.
REQ-018 Port result, output, 32, final accumulator; held until next accepted start.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT, DONE.
REQ-020 IDLE: start=1 SHALL be accepted; clears idx, acc=0x00000000, error=0, result=0x00000000.
REQ-021 Accepted start with len=0 SHALL go to DONE; result 0x00000000, error 0.
REQ-022 Accepted start with len>DEPTH SHALL go to DONE with error=1, no MAC issue.
REQ-023 Otherwise IDLE->ISSUE; ISSUE SHALL assert mac_tvalid exactly one cycle with a=buf_a[idx], b=buf_b[idx], c=acc, then go to WAIT.
REQ-024 mac_tvalid SHALL be 0 in all states except ISSUE; mac_*_tdata don't-care when mac_tvalid=0.
REQ-025 WAIT: mac_res_tvalid=1 SHALL capture acc<=mac_res_tdata, idx<=idx+1, clear timeout counter; next state ISSUE if idx+1<len, else DONE.
REQ-026 WAIT: timeout counter SHALL increment each cycle without mac_res_tvalid; reaching TIMEOUT SHALL go to DONE with error=1, result=acc.
REQ-027 mac_res_tvalid outside WAIT SHALL be ignored.
REQ-028 DONE SHALL assert done for exactly one cycle, load result<=acc, then return to IDLE.
REQ-029 Latency: start sampled at cycle 0, MAC latency L, len=N valid -> done high at cycle N*(L+1)+1.
REQ-030 start while busy SHALL be ignored; len sampled only on accepted start.
REQ-031 wr_en while busy SHALL be ignored; in IDLE writes land in next cycle; wr_en and start same cycle: write takes effect, start uses pre-write contents.
REQ-032 No floating-point arithmetic in this block; acc is an opaque 32-bit register.

Reset
REQ-033 rst_n low SHALL asynchronously force IDLE, idx=0, acc=0, counter=0, busy=0, done=0, error=0, mac_tvalid=0, result=0x00000000.
REQ-034 Reset mid-operation SHALL abort without a done pulse; operand buffer contents need not be cleared.

Structure
REQ-035 Shared package fp_seq_pkg SHALL hold the state enum, DEPTH default, FP_ZERO=32'h00000000.
REQ-036 Operand storage SHALL be sub-module fp_operand_buf (DEPTH x 64-bit, one write port, one async read port).

Verification (behavioural MAC model, L=3)
REQ-037 Load a={0x3F800000,0x40000000,0x40400000}, b={0x40800000,0x40A00000,0x40C00000}, len=3, start -> done at cycle 13, result 0x42000000 (32.0), error 0.
REQ-038 len=0, start -> done at cycle 1, result 0x00000000, mac_tvalid never high.
REQ-039 len=9, start -> done, error=1, mac_tvalid never high.
REQ-040 MAC model never returns valid, len=1 -> done 66 cycles after start (1 issue + 64 wait + 1), error=1.
REQ-041 start and wr_en pulsed during busy -> no restart, buffer unchanged, result still 0x42000000 for the REQ-037 vectors.
REQ-042 rst_n low in WAIT -> next cycle busy=0, mac_tvalid=0, no done; subsequent start completes normally.
